// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus-decode constants and prefix-tracker state encoding used by
// the bus monitor and its fetch sampler.
package z80_bus_pkg;

    localparam logic [7:0] OP_CB    = 8'hCB;
    localparam logic [7:0] OP_DD    = 8'hDD;
    localparam logic [7:0] OP_ED    = 8'hED;
    localparam logic [7:0] OP_FD    = 8'hFD;
    localparam logic [7:0] OP_RETI2 = 8'h4D;
    localparam logic [7:0] OP_RETN2 = 8'h45;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CB   = 2'b01,
        ST_ED   = 2'b10,
        ST_IX   = 2'b11
    } prefix_state_e;

    function automatic logic is_index_prefix(input logic [7:0] op);
        return (op == OP_DD) || (op == OP_FD);
    endfunction

endpackage

// File: rtl/z80_bus_monitor_if.sv
// CPU-side bus signals observed by the monitor; the CPU (or bench) is the master.
interface z80_bus_monitor_if;
    logic       M1_n;
    logic       MREQ_n;
    logic       IORQ_n;
    logic       RD_n;
    logic [7:0] D;

    modport master (output M1_n, MREQ_n, IORQ_n, RD_n, D);
    modport slave  (input  M1_n, MREQ_n, IORQ_n, RD_n, D);
endinterface

// File: rtl/z80_fetch_sampler.sv
// Clock-enable qualified edge detection of opcode fetches and interrupt
// acknowledge, plus the opcode latch that holds the last byte of a fetch.
module z80_fetch_sampler
    import z80_bus_pkg::*;
(
    input  logic                   I_CLK,
    input  logic                   I_RESET,
    input  logic                   I_CLKEN,
    z80_bus_monitor_if.slave       bus,
    output logic                   o_spm1,
    output logic                   o_fetch_done,
    output logic [7:0]             o_op,
    output logic                   o_iack_rise
);

    logic       w_fetch;
    logic       w_spm1;
    logic       r_fetch;
    logic       r_spm1;
    logic [7:0] r_op;

    assign w_fetch = ~bus.M1_n & ~bus.MREQ_n & ~bus.RD_n;
    assign w_spm1  = ~bus.M1_n & ~bus.IORQ_n;

    // Previous-sample history and opcode capture; the last byte seen before RD rises wins.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_fetch <= 1'b0;
            r_spm1  <= 1'b0;
            r_op    <= 8'h00;
        end else if (I_CLKEN) begin
            r_fetch <= w_fetch;
            r_spm1  <= w_spm1;
            if (w_fetch) begin
                r_op <= bus.D;
            end
        end
    end

    assign o_spm1       = w_spm1;
    assign o_op         = r_op;
    assign o_fetch_done = I_CLKEN & ~w_fetch & r_fetch;
    assign o_iack_rise  = I_CLKEN & w_spm1 & ~r_spm1;

endmodule

// File: rtl/z80_bus_monitor.sv
// Passive Z80 bus decoder: tracks opcode prefixes to flag genuine RETI/RETN
// fetches and interrupt-acknowledge cycles for the Mode-2 daisy chain.
module z80_bus_monitor
    import z80_bus_pkg::*;
(
    input  logic             I_CLK,
    input  logic             I_RESET,
    input  logic             I_CLKEN,
    z80_bus_monitor_if.slave bus,
    output logic             O_SPM1,
    output logic             O_IACK,
    output logic             O_RETI,
    output logic             O_RETN
);

    logic          w_spm1;
    logic          w_fetch_done;
    logic [7:0]    w_op;
    logic          w_iack_rise;

    prefix_state_e r_state;
    prefix_state_e w_state_nxt;
    logic          w_reti_nxt;
    logic          w_retn_nxt;
    logic          r_iack;
    logic          r_reti;
    logic          r_retn;

    z80_fetch_sampler u_sampler (
        .I_CLK        (I_CLK),
        .I_RESET      (I_RESET),
        .I_CLKEN      (I_CLKEN),
        .bus          (bus),
        .o_spm1       (w_spm1),
        .o_fetch_done (w_fetch_done),
        .o_op         (w_op),
        .o_iack_rise  (w_iack_rise)
    );

    // Prefix state and one-enable-period pulse registers.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_state <= ST_IDLE;
            r_iack  <= 1'b0;
            r_reti  <= 1'b0;
            r_retn  <= 1'b0;
        end else if (I_CLKEN) begin
            r_state <= w_state_nxt;
            r_iack  <= w_iack_rise;
            r_reti  <= w_reti_nxt;
            r_retn  <= w_retn_nxt;
        end
    end

    // Next prefix state; an acknowledge overrides any coincident fetch completion.
    always_comb begin
        w_state_nxt = r_state;
        w_reti_nxt  = 1'b0;
        w_retn_nxt  = 1'b0;
        if (w_iack_rise) begin
            w_state_nxt = ST_IDLE;
        end else if (w_fetch_done) begin
            case (r_state)
                ST_IDLE, ST_IX: begin
                    if (w_op == OP_ED) begin
                        w_state_nxt = ST_ED;
                    end else if (is_index_prefix(w_op)) begin
                        w_state_nxt = ST_IX;
                    end else if ((w_op == OP_CB) && (r_state == ST_IDLE)) begin
                        w_state_nxt = ST_CB;
                    end else begin
                        // DD CB d op: displacement and opcode are non-M1 reads
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_ED: begin
                    w_state_nxt = ST_IDLE;
                    if (w_op == OP_RETI2) begin
                        w_reti_nxt = 1'b1;
                    end else if (w_op == OP_RETN2) begin
                        w_retn_nxt = 1'b1;
                    end else begin
                        w_reti_nxt = 1'b0;
                    end
                end
                ST_CB: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    assign O_SPM1 = w_spm1;
    assign O_IACK = r_iack;
    assign O_RETI = r_reti;
    assign O_RETN = r_retn;

endmodule

// File: tb/tb_z80_bus_monitor.sv
// Scoreboard bench for z80_bus_monitor: each bus step queues the expected
// {IACK,RETI,RETN} after its enable edge, popped and compared once the edge occurs.
module tb_z80_bus_monitor;

    logic I_CLK;
    logic I_RESET;
    logic I_CLKEN;
    logic O_SPM1;
    logic O_IACK;
    logic O_RETI;
    logic O_RETN;

    z80_bus_monitor_if bus ();

    z80_bus_monitor dut (
        .I_CLK   (I_CLK),
        .I_RESET (I_RESET),
        .I_CLKEN (I_CLKEN),
        .bus     (bus),
        .O_SPM1  (O_SPM1),
        .O_IACK  (O_IACK),
        .O_RETI  (O_RETI),
        .O_RETN  (O_RETN)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         div = 1;
    int         reti_hi_cycles = 0;
    int         reti_samples = 0;
    logic [2:0] exp_q[$];

    initial begin
        I_CLK = 1'b0;
        forever #5 I_CLK = ~I_CLK;
    end

    // Counts how many enabled consumer edges observe O_RETI high.
    always @(posedge I_CLK) begin
        if (I_CLKEN && O_RETI) reti_samples <= reti_samples + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic m1, input logic mreq, input logic iorq, input logic rd,
                        input logic [7:0] d, input logic [2:0] exp, input string tag);
        logic [2:0] e;
        bus.M1_n   = m1;
        bus.MREQ_n = mreq;
        bus.IORQ_n = iorq;
        bus.RD_n   = rd;
        bus.D      = d;
        exp_q.push_back(exp);
        #1;
        check({tag, "_spm1"}, {31'd0, O_SPM1}, {31'd0, ~m1 & ~iorq});
        e = 3'b000;
        for (int k = 0; k < div; k++) begin
            I_CLKEN = (k == 0);
            @(posedge I_CLK);
            #1;
            if (k == 0) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check(tag, {29'd0, O_IACK, O_RETI, O_RETN}, {29'd0, e});
                end else begin
                    check({tag, "_sb_empty"}, 32'd1, 32'd0);
                end
            end else if (O_IACK || O_RETI || O_RETN || (e != 3'b000)) begin
                check({tag, "_hold"}, {29'd0, O_IACK, O_RETI, O_RETN}, {29'd0, e});
            end
            if (O_RETI) reti_hi_cycles++;
        end
    endtask

    task automatic idle(input string tag);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 3'b000, tag);
    endtask

    task automatic fetch(input logic [7:0] op, input logic reti, input logic retn, input string tag);
        step(1'b0, 1'b0, 1'b1, 1'b0, op, 3'b000, tag);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, {1'b0, reti, retn}, tag);
    endtask

    task automatic mem_read(input logic [7:0] op, input string tag);
        step(1'b1, 1'b0, 1'b1, 1'b0, op, 3'b000, tag);
        idle(tag);
    endtask

    task automatic iack_cycle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, (i == 0) ? 3'b100 : 3'b000, tag);
        end
        idle(tag);
    endtask

    task automatic pulse_reset(input string tag);
        I_RESET = 1'b1;
        I_CLKEN = 1'b1;
        @(posedge I_CLK);
        #1;
        check(tag, {29'd0, O_IACK, O_RETI, O_RETN}, 32'd0);
        I_RESET = 1'b0;
    endtask

    initial begin
        I_RESET    = 1'b1;
        I_CLKEN    = 1'b1;
        bus.M1_n   = 1'b1;
        bus.MREQ_n = 1'b1;
        bus.IORQ_n = 1'b1;
        bus.RD_n   = 1'b1;
        bus.D      = 8'h00;
        repeat (2) @(posedge I_CLK);
        #1;
        check("reset_out", {29'd0, O_IACK, O_RETI, O_RETN}, 32'd0);
        check("reset_spm1", {31'd0, O_SPM1}, 32'd0);
        I_RESET = 1'b0;
        idle("start");

        fetch(8'hED, 1'b0, 1'b0, "reti_p");
        fetch(8'h4D, 1'b1, 1'b0, "reti_op");
        idle("reti_end");

        fetch(8'hED, 1'b0, 1'b0, "retn_p");
        fetch(8'h45, 1'b0, 1'b1, "retn_op");
        idle("retn_end");

        fetch(8'hCB, 1'b0, 1'b0, "cb_p");
        fetch(8'hED, 1'b0, 1'b0, "cb_ed");
        fetch(8'h4D, 1'b0, 1'b0, "cb_4d");

        fetch(8'hDD, 1'b0, 1'b0, "ddcb_dd");
        fetch(8'hCB, 1'b0, 1'b0, "ddcb_cb");
        mem_read(8'hED, "ddcb_d");
        mem_read(8'h4D, "ddcb_op");
        fetch(8'h00, 1'b0, 1'b0, "ddcb_nop");

        fetch(8'hDD, 1'b0, 1'b0, "dd_p");
        fetch(8'hED, 1'b0, 1'b0, "dd_ed");
        fetch(8'h4D, 1'b1, 1'b0, "dd_4d");
        idle("dd_end");

        fetch(8'hED, 1'b0, 1'b0, "eded_1");
        fetch(8'hED, 1'b0, 1'b0, "eded_2");
        fetch(8'h4D, 1'b0, 1'b0, "eded_4d");

        fetch(8'hED, 1'b0, 1'b0, "b2b_ed1");
        fetch(8'h4D, 1'b1, 1'b0, "b2b_4d1");
        fetch(8'hED, 1'b0, 1'b0, "b2b_ed2");
        fetch(8'h4D, 1'b1, 1'b0, "b2b_4d2");
        idle("b2b_end");

        iack_cycle(3, "iack3");

        fetch(8'hED, 1'b0, 1'b0, "ack_ed");
        iack_cycle(1, "ack_mid");
        fetch(8'h4D, 1'b0, 1'b0, "ack_4d");

        fetch(8'hED, 1'b0, 1'b0, "rst_ed");
        pulse_reset("rst_pulse");
        fetch(8'h4D, 1'b0, 1'b0, "rst_4d");
        idle("rst_end");

        div = 4;
        idle("div4_start");
        reti_hi_cycles = 0;
        @(posedge I_CLK);
        #1;
        reti_samples = 0;
        fetch(8'hED, 1'b0, 1'b0, "div4_ed");
        fetch(8'h4D, 1'b1, 1'b0, "div4_4d");
        idle("div4_end");
        check("div4_width", reti_hi_cycles, 32'd4);
        check("div4_samples", reti_samples, 32'd1);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/z80_bus_monitor.md
# z80_bus_monitor

Passive Z80 bus decoder that drives the shared daisy-chain control inputs `I_SPM1` and `I_RETI` of every Mode-2 interrupt peripheral, including z80ctc.
- Detects interrupt-acknowledge cycles.
- Tracks opcode-fetch prefix state, so that only a genuine `ED 4D` (RETI) or `ED 45` (RETN) fetch sequence produces a pulse.
- Sits beside the CPU core, never drives the CPU bus, and shares the peripherals' `I_CLK`/`I_CLKEN`.

## Interface
Parameters: none.

- `I_CLK`     in   1  system clock; all state on rising edge
- `I_RESET`   in   1  synchronous, active-high reset
- `I_CLKEN`   in   1  CPU clock enable; bus is sampled and state advances only when high
- `I_M1_n`    in   1  CPU M1, active low
- `I_MREQ_n`  in   1  CPU MREQ, active low
- `I_IORQ_n`  in   1  CPU IORQ, active low
- `I_RD_n`    in   1  CPU RD, active low
- `I_D`       in   8  CPU data-in bus (opcode byte during fetch)
- `O_SPM1`    out  1  interrupt-acknowledge level: `~I_M1_n & ~I_IORQ_n`, combinational
- `O_IACK`    out  1  one-`I_CLKEN`-sample pulse at the start of an acknowledge cycle
- `O_RETI`    out  1  one-`I_CLKEN`-sample pulse after a completed `ED 4D` fetch
- `O_RETN`    out  1  one-`I_CLKEN`-sample pulse after a completed `ED 45` fetch

## Operation
- **Fetch detection:** `fetch = ~M1_n & ~MREQ_n & ~RD_n`.
  - On each `I_CLKEN` cycle, `fetch_r <= fetch`.
  - While `fetch` is high, `op_r <= I_D`, so the last sample before RD rises wins.
  - A fetch completes on the `I_CLKEN` cycle where `fetch==0 && fetch_r==1`. The decoder then evaluates `op_r`.
- **Prefix FSM:** 2-bit state; reset state is IDLE. Transitions happen only on fetch completion.
  - **IDLE:**
    - `CB` → CB
    - `ED` → ED
    - `DD`/`FD` → IX
    - else → IDLE
  - **IX:**
    - `CB` → IDLE; the displacement and opcode that follow are non-M1 reads and must not be decoded.
    - `DD`/`FD` → IX
    - `ED` → ED
    - else → IDLE
  - **CB:** any byte → IDLE. This guarantees that `CB ED` (SET 5,L) followed by a `4D` fetch is not treated as RETI.
  - **ED:**
    - `4D` → IDLE, and pulse `O_RETI`
    - `45` → IDLE, and pulse `O_RETN`
    - any other byte, including `ED` → IDLE
- **Acknowledge:**
  - `O_SPM1` is a pure level.
  - `O_IACK` fires on the first `I_CLKEN` sample with `O_SPM1` high after a sample with it low.
  - An acknowledge forces the FSM to IDLE (IM2 only; the vector is never decoded as an opcode).
- **Pulse width:** pulse outputs are registered. Each is set on the detecting `I_CLKEN` edge and cleared on the next `I_CLKEN` edge. Every consumer enabled by `I_CLKEN` therefore samples it exactly once.
- **Reset:**
  - Resetting mid-sequence drops any pending prefix state.
  - An `ED` fetched before reset followed by `4D` after reset produces no pulse.

## Timing
- **Reset values:**
  - `O_IACK`, `O_RETI`, `O_RETN` = 0.
  - FSM = IDLE, `fetch_r` = 0, `op_r` = 0x00.
  - `O_SPM1` follows its inputs.
- **Latency:**
  - `O_RETI`/`O_RETN` rise at the first `I_CLKEN` edge after RD/MREQ/M1 deassert at the end of the second fetch, and stay high for one `I_CLKEN` period.
  - `O_IACK` rises at the first `I_CLKEN` edge that sees `M1 & IORQ` low.
- **Gating:** when `I_CLKEN` is low, all registers hold.
- **Simultaneous events:** an acknowledge and a fetch completion cannot overlap on a legal bus. If they do, the acknowledge wins: FSM → IDLE and no RETI/RETN pulse.
- **Back-to-back fetches:** `ED 4D ED 4D` must give two pulses. This requires at least one `I_CLKEN` sample with `fetch` low between fetches, which the Z80 refresh phase guarantees.

## Structure
- **Shared package `z80_bus_pkg`:**
  - Opcode constants `OP_CB=8'hCB`, `OP_DD=8'hDD`, `OP_ED=8'hED`, `OP_FD=8'hFD`, `OP_RETI2=8'h4D`, `OP_RETN2=8'h45`.
  - FSM state encoding.
- **Sub-module `z80_fetch_sampler`:** clken-qualified edge detection of `fetch` and the acknowledge condition, plus the `op_r` latch. It outputs `fetch_done`, `op_r` and `iack_rise`.
- The FSM and pulse registers live in the top module.

## Test plan
- Fetch `ED`, then `4D` → `O_RETI` high for exactly one `I_CLKEN` period after the second fetch ends; `O_RETN` stays 0.
- Fetch `ED`, then `45` → a single `O_RETN` pulse; `O_RETI` stays 0.
- Fetch `CB`, `ED`, `4D` → no pulses. Fetch `DD`, `CB`, then non-M1 reads `ED`, `4D`, then M1 fetch `00` → no pulses.
- Fetch `DD`, `ED`, `4D` → one `O_RETI` pulse. Fetch `ED`, `ED`, `4D` → no pulse.
- Drive `M1_n=0`, `IORQ_n=0` for 3 `I_CLKEN` cycles → `O_SPM1` high throughout, `O_IACK` high for exactly one sample. After fetch `ED`, an acknowledge, then fetch `4D` → no `O_RETI`.
- Fetch `ED`; assert `I_RESET` for one cycle; fetch `4D` → no pulse.
- With `I_CLKEN` toggling 1-of-4, repeat the first scenario → the pulse spans 4 `I_CLK` cycles and is sampled once.
